// File: rtl/smu_traceback.sv
// Traceback survivor memory for a Viterbi decoder: stores one decision column per
// accepted trellis step and traces back TB_DEPTH steps from the best state once full.
module smu_traceback #(
  parameter int K        = 3,
  parameter int MW       = 4,
  parameter int TB_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1 << (K-1))-1:0]     dec,
  input  logic [(1 << (K-1))*MW-1:0]  pm,
  input  logic                        start_zero,
  output logic                        out_valid,
  output logic                        out_bit,
  output logic [K-2:0]                best_state,
  output logic                        o_dbg_state
);

  localparam int S  = 1 << (K-1);
  localparam int SL = K-1;
  localparam int PW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam int FW = $clog2(TB_DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(TB_DEPTH-1);
  localparam logic [FW-1:0] FULL = FW'(TB_DEPTH);

  // Handshake: a column is taken on any rising edge where in_valid && in_ready;
  // in_ready depends only on the FSM state, never on in_valid.
  typedef enum logic {ST_IDLE = 1'b0, ST_TRACE = 1'b1} state_t;

  state_t        r_state, w_state_next;
  logic [S-1:0]  r_mem [TB_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_j, w_wr_ptr_next, w_rd_idx;
  logic [FW-1:0] r_fill, w_fill_next;
  logic [SL-1:0] r_st, r_best, w_argmin, w_st_pred;
  logic [MW-1:0] w_min_val;
  logic          w_accept, w_d, w_last, r_out_valid, r_out_bit;

  assign w_accept      = in_valid && (r_state == ST_IDLE);
  assign w_wr_ptr_next = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_fill_next   = (r_fill == FULL) ? FULL : r_fill + 1'b1;
  // Column (wr_ptr - 1 - j) mod D without a divider; the result always fits in PW bits.
  assign w_rd_idx      = (r_wr_ptr > r_j) ? (r_wr_ptr - 1'b1 - r_j) : (r_wr_ptr + LAST - r_j);
  assign w_d           = r_mem[w_rd_idx][r_st];
  assign w_st_pred     = {r_st[SL-2:0], w_d};
  assign w_last        = (r_j == LAST);

  always_comb begin
    w_argmin  = '0;
    w_min_val = pm[MW-1:0];
    for (int i = 1; i < S; i++) begin
      if (pm[i*MW +: MW] < w_min_val) begin
        w_min_val = pm[i*MW +: MW];
        w_argmin  = SL'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && (w_fill_next == FULL)) w_state_next = ST_TRACE;
      ST_TRACE: if (w_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE);
    o_dbg_state = (r_state == ST_TRACE);
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_mem[r_wr_ptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_st        <= '0;
      r_j         <= '0;
      r_best      <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_wr_ptr <= w_wr_ptr_next;
        r_fill   <= w_fill_next;
        r_best   <= w_argmin;
        r_st     <= start_zero ? '0 : w_argmin;
        r_j      <= '0;
      end else if (r_state == ST_TRACE) begin
        r_st <= w_st_pred;
        if (w_last) begin
          r_out_bit   <= w_st_pred[SL-1];
          r_out_valid <= 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_bit    = r_out_bit;
  assign best_state = r_best;

endmodule

// File: doc/smu_traceback.md
# smu_traceback

Parametrised traceback survivor memory unit for the Viterbi decoder. It sits after the add-compare-select stage and accepts one column of per-state decision bits plus path metrics per trellis step. It stores the columns in a circular survivor buffer and, once the buffer is full, traces back `TB_DEPTH` steps from the minimum-metric state to emit one decoded bit per accepted step. It generalises the fixed 4-state, 2-bit survivor selector to any constraint length, metric width and traceback depth, with a valid/ready handshake.

## Interface
- `K`, default 3: constraint length; number of states S = 2^(K-1); K >= 3.
- `MW`, default 4: path-metric width (unsigned).
- `TB_DEPTH`, default 8: traceback depth D in trellis steps; D >= 2; need not be a power of two.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: column present on `dec`/`pm`.
- `in_ready`  out  1: high only in IDLE; a column is accepted when `in_valid && in_ready`.
- `dec`  in  S: decision bit for state i at `dec[i]`.
- `pm`  in  S*MW: metric of state i at `pm[i*MW +: MW]`.
- `start_zero`  in  1: sampled on accept; 1 forces the traceback start state to 0 (terminated trellis).
- `out_valid`  out  1: one-cycle pulse; `out_bit` is valid.
- `out_bit`  out  1: decoded bit.
- `best_state`  out  K-1: registered argmin state of the last accepted column.

## Operation
- **Trellis convention:** the state holds the last K-1 inputs, newest in the MSB.
  - Predecessor of state s with decision d is `((s << 1) & (S-1)) | d`.
  - The decoded bit is the MSB of the state reached after D traceback updates.
- **Storage:** a D x S register array, write pointer `wr_ptr` in 0..D-1, and fill count `fill` saturating at D.
- **On accept:**
  - Write `dec` at `wr_ptr`; advance `wr_ptr` with explicit wrap at D-1 -> 0; increment `fill` (saturating at D).
  - Register `best_state` = argmin of the S unsigned metrics, with the lowest index winning ties.
  - If `fill` after the write equals D, go to TRACE.
  - Start state `st` = 0 if `start_zero`, else the argmin just computed.
- **FSM IDLE:** `in_ready`=1. `in_valid` while in TRACE is ignored: no write, no pointer or fill change.
- **FSM TRACE:** `in_ready`=0; counter j runs 0..D-1.
  - Each cycle: read column `(wr_ptr - 1 - j) mod D` (with `wr_ptr` already advanced), set `d = col[st]`, and update `st` to its predecessor.
  - On j = D-1: register `out_bit` = MSB of the updated `st`, set `out_valid`=1 for the next cycle, and return to IDLE.
- While `fill` < D, accepts store columns only and produce no output.
- **Reset (including mid-TRACE):**
  - Aborts any traceback with no `out_valid` produced.
  - Clears `wr_ptr`, `fill`, `st`, `j`, `best_state`, `out_bit`, `out_valid`.
  - FSM goes to IDLE, so `in_ready`=1 from the cycle after reset. Buffer contents need not be cleared.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_bit`=0, `best_state`=0.
- **Traceback cycle sequence:**
  - Accept at edge 0 (fill reaches D).
  - TRACE occupies cycles 1..D, with `in_ready`=0 throughout.
  - `out_valid` is high in cycle D+1, and `in_ready`=1 in that same cycle.
- **Throughput:** once full, one column every D+1 cycles.
- `best_state` updates the cycle after accept.
- **Simultaneous accept in the `out_valid` cycle:** legal; it starts the next traceback immediately.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid`=1 -> `in_ready`=1, `out_valid`=0, `best_state`=0, no write.
- **Fill/latency (K=3, D=8), all `dec`=0:**
  - Accept 7 columns -> no `out_valid`.
  - 8th column -> `in_ready` low for exactly 8 cycles, `out_valid` pulse in cycle 9 with `out_bit`=0.
- **All-ones path:** all `dec`=4'b1111, `pm` = {7,9,5,3} (state 0..3) -> `best_state`=3, trace stays in state 3, `out_bit`=1.
- **Tie and `start_zero`:**
  - `pm` = {5,2,2,7} -> `best_state`=1.
  - With `start_zero`=1 and all `dec`=1 -> trace 0->1->3..., `out_bit`=1.
  - With `start_zero`=1 and all `dec`=0 -> `out_bit`=0.
- **Wrap-around and backpressure:**
  - Stream 25 random columns with `in_valid` held high, including during TRACE.
  - Only accepted columns are written, and `wr_ptr` wraps 7->0.
  - `out_bit` sequence matches a golden behavioural traceback model for K=3/D=8 and K=5/D=13.
- **Reset mid-TRACE:** pulse `rst` at TRACE cycle 4 -> no `out_valid`, `fill`=0, and the next 8 accepts are required before the next output.
